wash_cycle_ctrl: RTL
====================

// Module: wash_cycle_ctrl
// PURPOSE
// - Washer/dryer phase sequencer; sits directly downstream of the coin/countdown timer stage.
// - Consumes the minute tick (SLWCLK) and the remaining-credit BCD value {dollars,ten_minutes,minutes}.
// - Steps FILL->WASH->RINSE->SPIN (wash) or DRY (dryer); drives door lock, RUN gate, status LEDs.
// PARAMETERS
// - FILL_MIN   1  minutes in FILL
// - WASH_MIN   4  minutes in WASH
// - RINSE_MIN  2  minutes per RINSE pass
// - SPIN_MIN   1  minutes in SPIN
// - DRY_MIN    5  minutes in DRY
// - All 1..15 (4-bit phase counter).
// PORTS
// - CLK100MHZ  in   1   system clock, 100 MHz; sole clock
// - RST        in   1   synchronous, active-high reset
// - SLWCLK     in   1   slow minute clock from timer stage (async-ish level); rising edge = 1 minute
// - VALUE      in   12  remaining credit BCD {dollars,ten_minutes,minutes}
// - SW         in   6   SW[0]=dryer mode, SW[1]=extra rinse, SW[5:2] unused
// - START      in   1   start/resume button level
// - DOOR_OPEN  in   1   door sensor, 1=open
// - RUN        out  1   1 while a timed phase is active; gates upstream countdown
// - LOCK       out  1   door lock, 1 in FILL/WASH/RINSE/SPIN/DRY
// - DONE       out  1   1 in DONE state
// - PHASE      out  3   current state code
// - LED        out  16  [5:0] one-hot FILL,WASH,RINSE,SPIN,DRY,DONE; [6]=LOCK; [7]=PAUSE; [15:8]=0
// - CHIME      out  1   end-of-cycle beeper (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state IDLE, phase counter 0, rinse-pass flag 0; RUN/LOCK/DONE/CHIME=0, PHASE=0, LED=0.
// - SLWCLK, START: 2-FF sync + rising-edge detect -> 1-cycle tick/start pulse, 3 cycles after input rise.
// - States: IDLE=0 FILL=1 WASH=2 RINSE=3 SPIN=4 DRY=5 DONE=6 PAUSE=7; transitions on clock after pulse.
// - IDLE: start pulse && !DOOR_OPEN && VALUE!=0 -> DRY if SW[0] else FILL; SW sampled here only.
// - Start with VALUE==0 or door open: ignored, stay IDLE.
// - Timed phase: each tick increments counter; counter reaching phase length -> next phase, counter=0.
// - Order: FILL->WASH->RINSE->(RINSE again if SW[1] latched, once)->SPIN->DONE; DRY->DONE.
// - VALUE==0 in any timed phase -> DONE next cycle (credit exhausted beats phase order).
// - DOOR_OPEN=1 in timed phase -> PAUSE; phase, counter, rinse flag held; RUN=0, LOCK=0.
// - PAUSE: start pulse && !DOOR_OPEN -> resume saved phase, counter unchanged.
// - Same cycle tick + DOOR_OPEN: door wins, tick discarded (no count).
// - Same cycle tick + VALUE==0: DONE wins.
// - DONE: DOOR_OPEN rising (sync'd) or start pulse -> IDLE; counter cleared.
// - Ticks outside timed phases ignored; counter never wraps (cleared at length).
// - RST mid-cycle: IDLE on next clock, all outputs to reset values; no resume.
// CONFIGURATION
// - Macro DONE_CHIME_EN defined: on DONE entry CHIME=1, toggles on each tick, forced 0 after 3 ticks or leaving DONE.
// - Macro DONE_CHIME_EN undefined: CHIME tied 0; port kept for pin-compatible top.
// STRUCTURE
// - cycle_defs.vh: state codes, LED bit indices, default phase lengths.
// - Sub-module edge_sync: 2-FF synchronizer + rising-edge pulse; instantiated for SLWCLK, START, DOOR_OPEN.
// - Body: one registered FSM + 4-bit phase counter + rinse-pass flag + saved-phase register.
// TESTING
// - RST, SW=0, VALUE=12'h130, START pulse, 8 ticks -> FILL(1),WASH(4),RINSE(2),SPIN(1), DONE; LED[5]=1.
// - SW=6'b000001, VALUE=12'h100, START, 5 ticks -> DRY then DONE; RUN=1 only in DRY.
// - WASH after 2 ticks, DOOR_OPEN=1 -> PAUSE, RUN=0, LED[7]=1; close + START -> WASH, 2 more ticks to RINSE.
// - In RINSE, VALUE forced 12'h000 -> DONE next cycle; tick + DOOR_OPEN same cycle -> PAUSE, counter unchanged.
// - IDLE, VALUE=0, START -> stays IDLE; RST asserted in SPIN -> IDLE, all outputs 0 next clock.
// - DONE_CHIME_EN set: CHIME high on DONE, toggles 3 ticks then 0; undefined: CHIME stays 0.

Source files
------------

// File: rtl/wash_cycle_ctrl_pkg.sv
// Shared definitions for the washer/dryer phase sequencer: state codes,
// status-LED bit positions, default phase lengths and small decode helpers.
// Optional feature macro used by the top level: DONE_CHIME_EN.
package wash_cycle_ctrl_pkg;

    // State codes are visible on the PHASE output, so the encoding is fixed.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4,
        ST_DRY   = 3'd5,
        ST_DONE  = 3'd6,
        ST_PAUSE = 3'd7
    } state_e;

    // Status LED bit positions.
    localparam int LED_FILL  = 0;
    localparam int LED_WASH  = 1;
    localparam int LED_RINSE = 2;
    localparam int LED_SPIN  = 3;
    localparam int LED_DRY   = 4;
    localparam int LED_DONE  = 5;
    localparam int LED_LOCK  = 6;
    localparam int LED_PAUSE = 7;

    // Default phase lengths in minutes (legal range 1..15).
    localparam logic [3:0] DEF_FILL_MIN  = 4'd1;
    localparam logic [3:0] DEF_WASH_MIN  = 4'd4;
    localparam logic [3:0] DEF_RINSE_MIN = 4'd2;
    localparam logic [3:0] DEF_SPIN_MIN  = 4'd1;
    localparam logic [3:0] DEF_DRY_MIN   = 4'd5;

    // True for the phases that consume minutes and keep the door locked.
    function automatic logic is_timed(input state_e s);
        logic timed;
        case (s)
            ST_FILL, ST_WASH, ST_RINSE, ST_SPIN, ST_DRY: timed = 1'b1;
            default:                                     timed = 1'b0;
        endcase
        return timed;
    endfunction

    // Phase that follows a completed timed phase (extra rinse handled by caller).
    function automatic state_e next_phase(input state_e s);
        state_e nxt;
        case (s)
            ST_FILL:  nxt = ST_WASH;
            ST_WASH:  nxt = ST_RINSE;
            ST_RINSE: nxt = ST_SPIN;
            ST_SPIN:  nxt = ST_DONE;
            ST_DRY:   nxt = ST_DONE;
            default:  nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    // Status LED image for a given state: one-hot phase, lock and pause bits.
    function automatic logic [15:0] led_pattern(input state_e s);
        logic [15:0] led;
        led = 16'h0000;
        case (s)
            ST_FILL:  led[LED_FILL]  = 1'b1;
            ST_WASH:  led[LED_WASH]  = 1'b1;
            ST_RINSE: led[LED_RINSE] = 1'b1;
            ST_SPIN:  led[LED_SPIN]  = 1'b1;
            ST_DRY:   led[LED_DRY]   = 1'b1;
            ST_DONE:  led[LED_DONE]  = 1'b1;
            ST_PAUSE: led[LED_PAUSE] = 1'b1;
            default:  led            = 16'h0000;
        endcase
        if (is_timed(s)) begin
            led[LED_LOCK] = 1'b1;
        end else begin
            led[LED_LOCK] = 1'b0;
        end
        return led;
    endfunction

endpackage

// File: rtl/wash_cycle_ctrl_if.sv
// Signal bundle between the timer/panel side and the phase sequencer.
// The master side drives minute clock, credit, switches and buttons;
// the slave side (the sequencer) drives lock, run gate and status.
interface wash_cycle_ctrl_if;

    logic        SLWCLK;
    logic [11:0] VALUE;
    logic [5:0]  SW;
    logic        START;
    logic        DOOR_OPEN;
    logic        RUN;
    logic        LOCK;
    logic        DONE;
    logic [2:0]  PHASE;
    logic [15:0] LED;
    logic        CHIME;

    modport master (
        output SLWCLK, VALUE, SW, START, DOOR_OPEN,
        input  RUN, LOCK, DONE, PHASE, LED, CHIME
    );

    modport slave (
        input  SLWCLK, VALUE, SW, START, DOOR_OPEN,
        output RUN, LOCK, DONE, PHASE, LED, CHIME
    );

endinterface

// File: rtl/wash_cycle_ctrl_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// The one-cycle pulse appears three clocks after the input rises.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic pulse_r;

    // Synchronize the input and register a pulse on its rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r  <= 1'b0;
            sync_r  <= 1'b0;
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            meta_r  <= din;
            sync_r  <= meta_r;
            prev_r  <= sync_r;
            pulse_r <= sync_r & ~prev_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washer/dryer phase sequencer. Counts minute ticks from the timer stage
// and steps FILL->WASH->RINSE(->RINSE)->SPIN->DONE, or DRY->DONE, while
// driving the door lock, the RUN gate back to the countdown and status LEDs.
// Optional feature: define DONE_CHIME_EN to enable the end-of-cycle chime;
// without it CHIME is held low but the pin remains.
module wash_cycle_ctrl
    import wash_cycle_ctrl_pkg::*;
#(
    parameter logic [3:0] FILL_MIN  = DEF_FILL_MIN,
    parameter logic [3:0] WASH_MIN  = DEF_WASH_MIN,
    parameter logic [3:0] RINSE_MIN = DEF_RINSE_MIN,
    parameter logic [3:0] SPIN_MIN  = DEF_SPIN_MIN,
    parameter logic [3:0] DRY_MIN   = DEF_DRY_MIN
) (
    input  logic             CLK100MHZ,
    input  logic             RST,
    wash_cycle_ctrl_if.slave bus
);

    // Synchronized event pulses.
    logic tick_s;
    logic start_s;
    logic door_rise_s;
    logic door_fall_s;
    logic door_lvl_s;
    logic credit_s;

    // FSM state and datapath registers.
    state_e     state_r;
    state_e     state_nxt_s;
    state_e     saved_r;
    state_e     saved_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic [3:0] cnt_inc_s;
    logic [3:0] phase_len_s;
    logic       extra_r;
    logic       extra_nxt_s;
    logic       pass_r;
    logic       pass_nxt_s;
    logic       door_r;

    // Registered outputs.
    logic        run_r;
    logic        lock_r;
    logic        done_r;
    logic [15:0] led_r;

    edge_sync u_tick_sync (
        .clk   (CLK100MHZ),
        .rst   (RST),
        .din   (bus.SLWCLK),
        .pulse (tick_s)
    );

    edge_sync u_start_sync (
        .clk   (CLK100MHZ),
        .rst   (RST),
        .din   (bus.START),
        .pulse (start_s)
    );

    edge_sync u_door_open_sync (
        .clk   (CLK100MHZ),
        .rst   (RST),
        .din   (bus.DOOR_OPEN),
        .pulse (door_rise_s)
    );

    // The closing edge goes through its own synchronizer so the reconstructed
    // door level has exactly the same latency as the tick and start pulses.
    edge_sync u_door_close_sync (
        .clk   (CLK100MHZ),
        .rst   (RST),
        .din   (~bus.DOOR_OPEN),
        .pulse (door_fall_s)
    );

    // Track the synchronized door level from its open/close edge pulses.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            door_r <= 1'b0;
        end else if (door_rise_s) begin
            door_r <= 1'b1;
        end else if (door_fall_s) begin
            door_r <= 1'b0;
        end else begin
            door_r <= door_r;
        end
    end

    // Door level in the same cycle as the edge pulse, so a tick arriving
    // together with the door opening is discarded rather than counted.
    assign door_lvl_s = door_rise_s | (door_r & ~door_fall_s);
    assign credit_s   = (bus.VALUE != 12'h000);
    assign cnt_inc_s  = cnt_r + 4'd1;

    // Select the length of the phase currently being timed.
    always_comb begin
        phase_len_s = 4'd1;
        case (state_r)
            ST_FILL:  phase_len_s = FILL_MIN;
            ST_WASH:  phase_len_s = WASH_MIN;
            ST_RINSE: phase_len_s = RINSE_MIN;
            ST_SPIN:  phase_len_s = SPIN_MIN;
            ST_DRY:   phase_len_s = DRY_MIN;
            default:  phase_len_s = 4'd1;
        endcase
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_nxt_s = state_r;
        saved_nxt_s = saved_r;
        cnt_nxt_s   = cnt_r;
        extra_nxt_s = extra_r;
        pass_nxt_s  = pass_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 4'd0;
                if (start_s && !door_lvl_s && credit_s) begin
                    pass_nxt_s  = 1'b0;
                    extra_nxt_s = bus.SW[1];
                    if (bus.SW[0]) begin
                        state_nxt_s = ST_DRY;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL, ST_WASH, ST_RINSE, ST_SPIN, ST_DRY: begin
                // Credit exhaustion overrides everything, then the door,
                // then ordinary minute counting.
                if (!credit_s) begin
                    state_nxt_s = ST_DONE;
                    cnt_nxt_s   = 4'd0;
                end else if (door_lvl_s) begin
                    state_nxt_s = ST_PAUSE;
                    saved_nxt_s = state_r;
                end else if (tick_s) begin
                    if (cnt_inc_s >= phase_len_s) begin
                        cnt_nxt_s = 4'd0;
                        if ((state_r == ST_RINSE) && extra_r && !pass_r) begin
                            state_nxt_s = ST_RINSE;
                            pass_nxt_s  = 1'b1;
                        end else begin
                            state_nxt_s = next_phase(state_r);
                        end
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_PAUSE: begin
                // Counter and rinse flag are held; resume where we left off.
                if (start_s && !door_lvl_s) begin
                    state_nxt_s = saved_r;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                cnt_nxt_s = 4'd0;
                if (door_rise_s || start_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State, phase counter, rinse flags and saved-phase registers.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state_r <= ST_IDLE;
            saved_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            extra_r <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            saved_r <= saved_nxt_s;
            cnt_r   <= cnt_nxt_s;
            extra_r <= extra_nxt_s;
            pass_r  <= pass_nxt_s;
        end
    end

    // Outputs are decoded from the next state so they change with the state.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            run_r  <= 1'b0;
            lock_r <= 1'b0;
            done_r <= 1'b0;
            led_r  <= 16'h0000;
        end else begin
            run_r  <= is_timed(state_nxt_s);
            lock_r <= is_timed(state_nxt_s);
            done_r <= (state_nxt_s == ST_DONE);
            led_r  <= led_pattern(state_nxt_s);
        end
    end

    assign bus.RUN   = run_r;
    assign bus.LOCK  = lock_r;
    assign bus.DONE  = done_r;
    assign bus.PHASE = state_r;
    assign bus.LED   = led_r;

`ifdef DONE_CHIME_EN
    logic       chime_r;
    logic [1:0] chime_cnt_r;

    // Chime: high on DONE entry, toggles per tick, silenced after three ticks.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            chime_r     <= 1'b0;
            chime_cnt_r <= 2'd0;
        end else if ((state_nxt_s == ST_DONE) && (state_r != ST_DONE)) begin
            chime_r     <= 1'b1;
            chime_cnt_r <= 2'd0;
        end else if (state_nxt_s != ST_DONE) begin
            chime_r     <= 1'b0;
            chime_cnt_r <= 2'd0;
        end else if (tick_s) begin
            if (chime_cnt_r < 2'd2) begin
                chime_r     <= ~chime_r;
                chime_cnt_r <= chime_cnt_r + 2'd1;
            end else begin
                chime_r     <= 1'b0;
                chime_cnt_r <= 2'd3;
            end
        end else begin
            chime_r     <= chime_r;
            chime_cnt_r <= chime_cnt_r;
        end
    end

    assign bus.CHIME = chime_r;
`else
    assign bus.CHIME = 1'b0;
`endif

endmodule
